// File: rtl/ysyx_22051013_lsu_mem_rsp.sv
// Load/store unit memory-response block: turns a held core request into one
// aligned memory access and returns a single-cycle completion pulse.
module ysyx_22051013_lsu_mem_rsp (
  input  logic        clk,
  input  logic        rst,
  input  logic        re,
  input  logic        we,
  input  logic        fencei,
  input  logic [63:0] data_pc,
  input  logic [63:0] ls_data,
  input  logic [2:0]  data_size,
  output logic        data_valid,
  output logic [63:0] data_temp,
  output logic        acc_err,
  output logic        mem_req,
  output logic        mem_we,
  output logic [63:0] mem_addr,
  output logic [63:0] mem_wdata,
  output logic [7:0]  mem_wstrb,
  input  logic        mem_gnt,
  input  logic        mem_rvalid,
  input  logic [63:0] mem_rdata
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RD_REQ  = 3'd1,
    RD_WAIT = 3'd2,
    WR_REQ  = 3'd3,
    RESP    = 3'd4,
    GAP     = 3'd5
  } state_t;

  state_t      state_reg, state_next;
  logic [63:0] addr_reg;
  logic [63:0] wdata_reg;
  logic [2:0]  size_reg;
  logic        err_reg;
  logic [63:0] data_temp_reg;

  function automatic logic [3:0] nbytes_of(input logic [2:0] size);
    case (size)
      3'b000:  nbytes_of = 4'd1;
      3'b001:  nbytes_of = 4'd2;
      3'b010:  nbytes_of = 4'd4;
      default: nbytes_of = 4'd8;
    endcase
  endfunction

  logic        accept;
  logic        in_misaligned;
  logic [2:0]  off;
  logic [63:0] rd_shifted;
  logic [63:0] rd_data;
  logic [7:0]  strb_base;

  assign accept        = (state_reg == IDLE) && (fencei || we || re);
  assign in_misaligned = ({1'b0, data_pc[2:0]} + nbytes_of(data_size)) > 4'd8;
  assign off           = addr_reg[2:0];
  assign rd_shifted    = mem_rdata >> {off, 3'b000};

  always_comb begin
    rd_data   = rd_shifted;
    strb_base = 8'hFF;
    case (size_reg)
      3'b000: begin rd_data = {56'd0, rd_shifted[7:0]};  strb_base = 8'h01; end
      3'b001: begin rd_data = {48'd0, rd_shifted[15:0]}; strb_base = 8'h03; end
      3'b010: begin rd_data = {32'd0, rd_shifted[31:0]}; strb_base = 8'h0F; end
      default: ;
    endcase
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: begin
        // fence.i never touches memory, so it skips the alignment check
        if (fencei)              state_next = RESP;
        else if (we || re) begin
          if (in_misaligned)     state_next = RESP;
          else if (we)           state_next = WR_REQ;
          else                   state_next = RD_REQ;
        end
      end
      RD_REQ:  if (mem_gnt)    state_next = RD_WAIT;
      RD_WAIT: if (mem_rvalid) state_next = RESP;
      WR_REQ:  if (mem_gnt)    state_next = RESP;
      RESP:    state_next = GAP;
      GAP:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg     <= IDLE;
      addr_reg      <= 64'd0;
      wdata_reg     <= 64'd0;
      size_reg      <= 3'd0;
      err_reg       <= 1'b0;
      data_temp_reg <= 64'd0;
    end else begin
      state_reg <= state_next;
      if (accept) begin
        addr_reg  <= data_pc;
        wdata_reg <= ls_data;
        size_reg  <= data_size;
        err_reg   <= !fencei && in_misaligned;
        if (!fencei && in_misaligned) data_temp_reg <= 64'd0;
      end
      if (state_reg == RD_WAIT && mem_rvalid) data_temp_reg <= rd_data;
    end
  end

  // Memory outputs derive only from latched request state, so they hold until granted
  assign data_valid = (state_reg == RESP);
  assign acc_err    = data_valid && err_reg;
  assign data_temp  = data_temp_reg;
  assign mem_req    = (state_reg == RD_REQ) || (state_reg == WR_REQ);
  assign mem_we     = (state_reg == WR_REQ);
  assign mem_addr   = {addr_reg[63:3], 3'b000};
  assign mem_wdata  = mem_we ? (wdata_reg << {off, 3'b000}) : 64'd0;
  assign mem_wstrb  = mem_we ? (strb_base << off) : 8'd0;

endmodule
